// File: rtl/worker_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : worker_ctrl_pkg
// Description : Shared state encoding, default parameters and derived widths
//               for the worker sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package worker_ctrl_pkg;

    localparam int DEF_Q               = 16;
    localparam int DEF_NSUB            = 16;
    localparam int DEF_VID_BW          = 16;
    localparam int DEF_VID_ADDR_SPACE  = 4;
    localparam int DEF_DIST_ADDR_SPACE = 16;
    localparam int DEF_LOC_ADDR_SPACE  = 4;
    localparam int DEF_NEXT_ADDR_SPACE = 4;
    localparam int DEF_PRO_ADDR_SPACE  = 4;
    localparam int DEF_BATCH_BW        = 8;
    localparam int DEF_ARG_LAT         = 2;

    localparam int Q_W   = $clog2(DEF_Q);
    localparam int SUB_W = $clog2(DEF_NSUB);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/worker_ctrl_wb.sv
`default_nettype none
// ============================================================================
// Module      : worker_ctrl_wb
// Description : Single-slot row write-back generator; fires ARG_LAT cycles
//               after the row's final accumulate beat, frozen by hold.
// Revision    : 1.0 - initial release
// ============================================================================
module worker_ctrl_wb #(
    parameter int BATCH_BW        = 8,
    parameter int NEXT_ADDR_SPACE = 4,
    parameter int PRO_ADDR_SPACE  = 4,
    parameter int ARG_LAT         = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic                       arm,
    input  logic                       arm_last,
    input  logic [BATCH_BW-1:0]        row,
    output logic                       wen,
    output logic                       done,
    output logic [NEXT_ADDR_SPACE-1:0] next_waddr,
    output logic [PRO_ADDR_SPACE-1:0]  pro_waddr
);
    localparam int CNT_W = $clog2(ARG_LAT + 1);

    logic                r_pend;
    logic                r_last;
    logic [CNT_W-1:0]    r_cnt;
    logic [BATCH_BW-1:0] r_row;
    logic [BATCH_BW-1:0] r_waddr;
    logic                r_wen;
    logic                r_done;

    // Arm happens on the last STREAM cycle, one cycle before the final beat,
    // so a count of ARG_LAT lands the strobe ARG_LAT cycles after that beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_row   <= '0;
            r_waddr <= '0;
            r_wen   <= 1'b0;
            r_done  <= 1'b0;
        end else if (!hold) begin
            r_wen  <= 1'b0;
            r_done <= 1'b0;
            if (arm) begin
                r_pend <= 1'b1;
                r_cnt  <= CNT_W'(ARG_LAT);
                r_row  <= row;
                r_last <= arm_last;
            end else if (r_pend) begin
                if (r_cnt == CNT_W'(1)) begin
                    r_pend  <= 1'b0;
                    r_wen   <= 1'b1;
                    r_done  <= r_last;
                    r_waddr <= r_row;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign wen  = r_wen;
    assign done = r_done;

    if (NEXT_ADDR_SPACE <= BATCH_BW) begin : g_next_trunc
        assign next_waddr = r_waddr[NEXT_ADDR_SPACE-1:0];
    end else begin : g_next_ext
        assign next_waddr = {{(NEXT_ADDR_SPACE-BATCH_BW){1'b0}}, r_waddr};
    end

    if (PRO_ADDR_SPACE <= BATCH_BW) begin : g_pro_trunc
        assign pro_waddr = r_waddr[PRO_ADDR_SPACE-1:0];
    end else begin : g_pro_ext
        assign pro_waddr = {{(PRO_ADDR_SPACE-BATCH_BW){1'b0}}, r_waddr};
    end

endmodule
`default_nettype wire

// File: rtl/worker_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : worker_ctrl
// Description : Batch sequencer issuing VID/DIST/LOC reads, accumulate strobes
//               and per-row NEXT/PRO write-backs for the worker datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module worker_ctrl
    import worker_ctrl_pkg::*;
#(
    parameter int Q               = DEF_Q,
    parameter int NSUB            = DEF_NSUB,
    parameter int VID_BW          = DEF_VID_BW,
    parameter int VID_ADDR_SPACE  = DEF_VID_ADDR_SPACE,
    parameter int DIST_ADDR_SPACE = DEF_DIST_ADDR_SPACE,
    parameter int LOC_ADDR_SPACE  = DEF_LOC_ADDR_SPACE,
    parameter int NEXT_ADDR_SPACE = DEF_NEXT_ADDR_SPACE,
    parameter int PRO_ADDR_SPACE  = DEF_PRO_ADDR_SPACE,
    parameter int BATCH_BW        = DEF_BATCH_BW,
    parameter int ARG_LAT         = DEF_ARG_LAT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [BATCH_BW-1:0]        batch_num,
    input  logic                       hold,
    input  logic [Q*VID_BW-1:0]        vid_rdata,
    output logic [VID_ADDR_SPACE-1:0]  vid_raddr,
    output logic [DIST_ADDR_SPACE-1:0] dist_raddr,
    output logic [LOC_ADDR_SPACE-1:0]  loc_raddr,
    output logic [VID_BW-1:0]          vid,
    output logic                       acc_valid,
    output logic                       acc_first,
    output logic                       acc_last,
    output logic                       next_wen,
    output logic                       pro_wen,
    output logic [NEXT_ADDR_SPACE-1:0] next_waddr,
    output logic [PRO_ADDR_SPACE-1:0]  pro_waddr,
    output logic                       batch_finish,
    output logic                       busy,
    output logic                       done
);
    localparam int QW    = $clog2(Q);
    localparam int SW    = LOC_ADDR_SPACE;
    localparam int TW    = QW + SW;
    localparam int IDX_W = DIST_ADDR_SPACE - LOC_ADDR_SPACE;

    state_t                     r_state;
    logic [BATCH_BW-1:0]        r_batch;
    logic [BATCH_BW-1:0]        r_row;
    logic [VID_BW-1:0]          r_row_buf [Q];
    logic [TW-1:0]              r_t;
    logic [VID_ADDR_SPACE-1:0]  r_vid_raddr;
    logic [DIST_ADDR_SPACE-1:0] r_dist_raddr;
    logic [SW-1:0]              r_loc_raddr;
    logic [VID_BW-1:0]          r_vid;
    logic                       r_acc_valid;
    logic                       r_acc_first;
    logic                       r_acc_last;
    logic                       r_busy;
    logic                       r_zero_done;

    logic [TW-1:0]              w_t_next;
    logic [QW-1:0]              w_v;
    logic [QW-1:0]              w_v_next;
    logic [SW-1:0]              w_s;
    logic [SW-1:0]              w_s_next;
    logic [BATCH_BW-1:0]        w_row_next;
    logic [VID_ADDR_SPACE-1:0]  w_vaddr_next;
    logic                       w_stream_end;
    logic                       w_last_row;
    logic                       w_arm;
    logic                       w_wb_wen;
    logic                       w_wb_done;

    assign w_t_next     = r_t + TW'(1);
    assign w_v          = r_t[TW-1:SW];
    assign w_s          = r_t[SW-1:0];
    assign w_v_next     = w_t_next[TW-1:SW];
    assign w_s_next     = w_t_next[SW-1:0];
    assign w_row_next   = r_row + BATCH_BW'(1);
    assign w_stream_end = (r_state == ST_STREAM) && (r_t == '1);
    assign w_last_row   = (r_row == r_batch - BATCH_BW'(1));
    assign w_arm        = w_stream_end && !hold;

    if (VID_ADDR_SPACE <= BATCH_BW) begin : g_vaddr_trunc
        assign w_vaddr_next = w_row_next[VID_ADDR_SPACE-1:0];
    end else begin : g_vaddr_ext
        assign w_vaddr_next = {{(VID_ADDR_SPACE-BATCH_BW){1'b0}}, w_row_next};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_batch      <= '0;
            r_row        <= '0;
            r_t          <= '0;
            r_vid_raddr  <= '0;
            r_dist_raddr <= '0;
            r_loc_raddr  <= '0;
            r_vid        <= '0;
            r_acc_valid  <= 1'b0;
            r_acc_first  <= 1'b0;
            r_acc_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_zero_done  <= 1'b0;
            for (int i = 0; i < Q; i++) r_row_buf[i] <= '0;
        end else if (!hold) begin
            r_acc_valid <= 1'b0;
            r_acc_first <= 1'b0;
            r_acc_last  <= 1'b0;
            r_zero_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_batch <= batch_num;
                        r_row   <= '0;
                        if (batch_num == '0) begin
                            r_zero_done <= 1'b1;
                        end else begin
                            r_state     <= ST_FETCH;
                            r_busy      <= 1'b1;
                            r_vid_raddr <= '0;
                        end
                    end
                end
                ST_FETCH: r_state <= ST_LATCH;
                ST_LATCH: begin
                    for (int i = 0; i < Q; i++) r_row_buf[i] <= vid_rdata[i*VID_BW +: VID_BW];
                    // First DIST address comes straight from the SRAM word, the
                    // buffer is only being written on this edge.
                    r_t          <= '0;
                    r_loc_raddr  <= '0;
                    r_dist_raddr <= {vid_rdata[IDX_W-1:0], {SW{1'b0}}};
                    r_state      <= ST_STREAM;
                end
                ST_STREAM: begin
                    r_acc_valid <= 1'b1;
                    r_acc_first <= (w_s == '0);
                    r_acc_last  <= (w_s == '1);
                    r_vid       <= r_row_buf[w_v];
                    if (w_stream_end) begin
                        if (w_last_row) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state     <= ST_FETCH;
                            r_row       <= w_row_next;
                            r_vid_raddr <= w_vaddr_next;
                        end
                    end else begin
                        r_t          <= w_t_next;
                        r_loc_raddr  <= w_s_next;
                        r_dist_raddr <= {r_row_buf[w_v_next][IDX_W-1:0], w_s_next};
                    end
                end
                ST_DRAIN: begin
                    if (w_wb_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    worker_ctrl_wb #(
        .BATCH_BW        (BATCH_BW),
        .NEXT_ADDR_SPACE (NEXT_ADDR_SPACE),
        .PRO_ADDR_SPACE  (PRO_ADDR_SPACE),
        .ARG_LAT         (ARG_LAT)
    ) u_wb (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .arm        (w_arm),
        .arm_last   (w_last_row),
        .row        (r_row),
        .wen        (w_wb_wen),
        .done       (w_wb_done),
        .next_waddr (next_waddr),
        .pro_waddr  (pro_waddr)
    );

    // Strobes are masked while frozen; the held registers re-emit them after.
    assign acc_valid    = r_acc_valid & ~hold;
    assign next_wen     = w_wb_wen & ~hold;
    assign pro_wen      = w_wb_wen & ~hold;
    assign batch_finish = w_wb_wen & ~hold;
    assign done         = (r_zero_done | w_wb_done) & ~hold;
    assign acc_first    = r_acc_first;
    assign acc_last     = r_acc_last;
    assign vid          = r_vid;
    assign vid_raddr    = r_vid_raddr;
    assign dist_raddr   = r_dist_raddr;
    assign loc_raddr    = r_loc_raddr;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_worker_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_worker_ctrl
// Description : Directed, table-driven bench for worker_ctrl with cycle-exact
//               expectations for beats, write-backs, done and busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_worker_ctrl;
    import worker_ctrl_pkg::*;

    localparam int QB = DEF_Q;
    localparam int VB = DEF_VID_BW;
    localparam int ROW_BEATS = DEF_Q * DEF_NSUB;
    localparam int PERIOD = ROW_BEATS + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic [7:0]    batch_num = '0;
    logic [QB*VB-1:0] vid_rdata = '0;
    logic [3:0]    vid_raddr, loc_raddr, next_waddr, pro_waddr;
    logic [15:0]   dist_raddr, vid;
    logic          acc_valid, acc_first, acc_last, next_wen, pro_wen;
    logic          batch_finish, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    worker_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .batch_num(batch_num),
        .hold(hold), .vid_rdata(vid_rdata), .vid_raddr(vid_raddr),
        .dist_raddr(dist_raddr), .loc_raddr(loc_raddr), .vid(vid),
        .acc_valid(acc_valid), .acc_first(acc_first), .acc_last(acc_last),
        .next_wen(next_wen), .pro_wen(pro_wen), .next_waddr(next_waddr),
        .pro_waddr(pro_waddr), .batch_finish(batch_finish), .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // VID SRAM contents: word v of row a is v*4096 + a*16 + v.
    function automatic logic [15:0] vid_of(input int row, input int v);
        return 16'(v * 4096 + (row % 16) * 16 + v);
    endfunction

    always @(posedge clk)
        for (int v = 0; v < QB; v++) vid_rdata[v*VB +: VB] <= vid_of(int'(vid_raddr), v);

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sh(input int c, input int at, input int len);
        return (len > 0 && c >= at) ? c + len : c;
    endfunction

    typedef struct {
        string name;
        int batch;
        int hold_at;
        int hold_len;
        int beats;
        int nfirst;
        int nwen;
        int first_valid;
        int last_valid;
        int done_cyc;
        int busy_off;
    } vec_t;

    vec_t vecs[6];

    // Called at #1 after a rising edge; that clock period is cycle 0.
    task automatic run_vec(input vec_t v);
        int beat = 0, nf = 0, nl = 0, nw = 0, nd = 0, dc = -1;
        int fv = -1, lv = -1, errs = 0, first_err = -1;
        int pd = 0, pl = 0;
        int snap_v = 0, snap_d = 0, snap_l = 0;
        for (int rc = 0; rc <= v.busy_off + 4; rc++) begin
            start = (rc == 0);
            batch_num = 8'(v.batch);
            hold = (v.hold_len > 0 && rc >= v.hold_at && rc < v.hold_at + v.hold_len);
            @(negedge clk);
            if (rc == 0) begin
                snap_v = int'(vid_raddr);
                snap_d = int'(dist_raddr);
                snap_l = int'(loc_raddr);
            end else begin
                logic bad;
                bad = 1'b0;
                if (hold && (acc_valid || next_wen || pro_wen || batch_finish || done)) bad = 1'b1;
                if (busy !== (v.batch != 0 && rc < v.busy_off)) bad = 1'b1;
                if (next_wen !== pro_wen || next_wen !== batch_finish || next_waddr !== pro_waddr) bad = 1'b1;
                if (acc_valid) begin
                    int r, t, vv, s;
                    r = beat / ROW_BEATS; t = beat % ROW_BEATS; vv = t / 16; s = t % 16;
                    if (beat >= v.beats || rc != sh(4 + PERIOD * r + t, v.hold_at, v.hold_len) ||
                        acc_first !== (s == 0) || acc_last !== (s == 15) ||
                        vid !== vid_of(r, vv) || pl != s ||
                        pd != ((r % 16) * 16 + vv) * 16 + s) bad = 1'b1;
                    if (fv < 0) fv = rc;
                    lv = rc;
                    beat++;
                    if (acc_first) nf++;
                    if (acc_last) nl++;
                end
                if (next_wen) begin
                    if (rc != sh(261 + PERIOD * nw, v.hold_at, v.hold_len) ||
                        int'(next_waddr) != nw % 16) bad = 1'b1;
                    nw++;
                end
                if (done) begin
                    nd++;
                    dc = rc;
                end
                for (int r2 = 0; r2 < v.batch; r2++)
                    if (rc == sh(1 + PERIOD * r2, v.hold_at, v.hold_len) &&
                        int'(vid_raddr) != r2 % 16) bad = 1'b1;
                if (bad) begin
                    errs++;
                    if (first_err < 0) first_err = rc;
                end
            end
            if (!hold) begin
                pd = int'(dist_raddr);
                pl = int'(loc_raddr);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        hold = 1'b0;
        check({v.name, " beats"}, beat, v.beats);
        check({v.name, " acc_first count"}, nf, v.nfirst);
        check({v.name, " acc_last count"}, nl, v.nfirst);
        check({v.name, " write-back count"}, nw, v.nwen);
        check({v.name, " done count"}, nd, 1);
        check({v.name, " done cycle"}, dc, v.done_cyc);
        check({v.name, " first acc_valid cycle"}, fv, v.first_valid);
        check({v.name, " last acc_valid cycle"}, lv, v.last_valid);
        check($sformatf("%s per-cycle errors (first at cycle %0d)", v.name, first_err), errs, 0);
        if (v.batch == 0) begin
            check({v.name, " vid_raddr unchanged"}, int'(vid_raddr), snap_v);
            check({v.name, " dist_raddr unchanged"}, int'(dist_raddr), snap_d);
            check({v.name, " loc_raddr unchanged"}, int'(loc_raddr), snap_l);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        //                name           bat hat hl beats nfst nwen fv  lv    done  boff
        vecs[0] = '{"batch1",          1,  0,  0, 256,  16,  1,  4, 259,  261,  262};
        vecs[1] = '{"batch2",          2,  0,  0, 512,  32,  2,  4, 517,  519,  520};
        vecs[2] = '{"batch0",          0,  0,  0, 0,    0,   0, -1, -1,   1,    1};
        vecs[3] = '{"batch18",        18,  0,  0, 4608, 288, 18, 4, 4645, 4647, 4648};
        vecs[4] = '{"hold_stream",     2, 100, 5, 512,  32,  2,  4, 522,  524,  525};
        vecs[5] = '{"hold_drain",      1, 260, 5, 256,  16,  1,  4, 259,  266,  267};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset acc_valid", int'(acc_valid), 0);
        check("reset done", int'(done), 0);
        check("reset vid_raddr", int'(vid_raddr), 0);
        check("reset dist_raddr", int'(dist_raddr), 0);
        check("reset next_wen", int'(next_wen), 0);
        check("reset next_waddr", int'(next_waddr), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset during row 1 LATCH while row 0's write-back is still pending.
        start = 1'b1;
        batch_num = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (259) @(posedge clk);
        #1;
        check("pre-reset vid_raddr row1", int'(vid_raddr), 1);
        check("pre-reset busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("async reset busy", int'(busy), 0);
        check("async reset vid_raddr", int'(vid_raddr), 0);
        check("async reset dist_raddr", int'(dist_raddr), 0);
        check("async reset loc_raddr", int'(loc_raddr), 0);
        check("async reset vid", int'(vid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (next_wen || done || acc_valid || busy || batch_finish) stale++;
        end
        check("stale activity after reset", stale, 0);
        @(posedge clk);
        #1;
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/worker_ctrl.md
Name: worker_ctrl

Overview:
Sequencer for the streaming-partition worker datapath. It walks a batch of vertex-ID rows and issues the VID, DIST and LOC SRAM read addresses for every sub-batch of every vertex. It tags the returned data with valid/first/last strobes for the worker's accumulate/argmax pipe, and issues the NEXT/PRO write-back strobes and addresses once per row. It sits between the top-level batch scheduler (start/done) and the worker datapath plus its SRAMs.

Parameters:
Q, 16, vertex IDs per VID SRAM row
NSUB, 16, sub-batches per vertex (N/D), power of two
VID_BW, 16, vertex ID width
VID_ADDR_SPACE, 4, VID SRAM address width
DIST_ADDR_SPACE, 16, DIST SRAM address width
LOC_ADDR_SPACE, 4, LOC SRAM address width; equals log2(NSUB)
NEXT_ADDR_SPACE, 4, NEXT SRAM address width
PRO_ADDR_SPACE, 4, PRO SRAM address width
BATCH_BW, 8, row-count width
ARG_LAT, 2, cycles from the last acc_valid of a row to its result being stable in the worker (1..8)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin batch
batch_num  in  BATCH_BW  rows to process, latched on start
hold  in  1  freeze the whole block this cycle
vid_rdata  in  Q*VID_BW  VID SRAM row, valid 1 cycle after vid_raddr
vid_raddr  out  VID_ADDR_SPACE  VID SRAM read address
dist_raddr  out  DIST_ADDR_SPACE  {vid[DIST_ADDR_SPACE-LOC_ADDR_SPACE-1:0], sub}
loc_raddr  out  LOC_ADDR_SPACE  sub-batch index
vid  out  VID_BW  vertex ID of the current acc_valid beat
acc_valid  out  1  DIST/LOC rdata valid for the worker this cycle
acc_first  out  1  beat is sub 0 of a vertex
acc_last  out  1  beat is sub NSUB-1 of a vertex
next_wen, pro_wen  out  1  row write-back strobe (identical)
next_waddr  out  NEXT_ADDR_SPACE  row index, zero-extended or truncated
pro_waddr  out  PRO_ADDR_SPACE  same as next_waddr
batch_finish  out  1  pulse with each row write-back
busy  out  1  batch in progress
done  out  1  pulse on the final row write-back

Behaviour:
- Async reset: state IDLE, all counters 0, every output 0.
- hold=1 freezes all state, counters and delay pipes. Outputs keep their values, except that strobes (acc_valid, wen, batch_finish, done) are forced to 0 during hold and re-emitted when hold drops.
- FSM IDLE -> FETCH -> LATCH -> STREAM -> (FETCH | DRAIN) -> IDLE.
- IDLE: on start, latch batch_num, row=0. If batch_num=0, pulse done next cycle and stay IDLE; busy stays 0. Otherwise go to FETCH with busy=1. start is ignored when not in IDLE.
- FETCH (1 cycle): vid_raddr = row mod 2^VID_ADDR_SPACE, so addresses wrap.
- LATCH (1 cycle): register vid_rdata into the row buffer.
- STREAM: Q*NSUB cycles. Cycle t issues vertex v=t/NSUB, sub s=t%NSUB, with loc_raddr=s and dist_raddr from row_buf[v]. acc_valid/first/last/vid are issued 1 cycle later (SRAM latency), matching the rdata.
- End of STREAM: arm the write-back timer for this row. If rows remain, go to FETCH (row+1); otherwise go to DRAIN.
- Write-back: the pulse on next_wen/pro_wen/batch_finish occurs ARG_LAT cycles after the row's final acc_valid, with waddr = that row's index. At most one write-back is in flight, since ARG_LAT < Q*NSUB+2.
- DRAIN: wait for the final write-back. done pulses in the same cycle as it. IDLE (busy=0) follows on the next cycle.
- Simultaneous events: the previous row's write-back overlapping the next row's FETCH/LATCH/STREAM is legal and independent.
- Per-row period is Q*NSUB+2 cycles.

Decomposition:
- Shared package: the state enum (IDLE/FETCH/LATCH/STREAM/DRAIN), the default parameter constants, and the derived widths log2(Q) and log2(NSUB).
- One sub-module, worker_ctrl_wb: a row-index + ARG_LAT delay-counter write-back generator (single slot, hold-aware).

Test Plan:
1. Defaults, start at cycle 0, batch_num=1 -> vid_raddr=0 in cycle 1. STREAM cycles 3..258 and acc_valid cycles 4..259. acc_first at 4, 20, ..., 244; acc_last at 19, ..., 259. wen/batch_finish/done at 261 with waddr=0. busy=0 from 262.
2. batch_num=2, vid_rdata row0 vid[v]=v*4096+v -> dist_raddr at cycle 3+16v+s equals {v[11:0], s}. Row1 FETCH at 259 with vid_raddr=1. Write-backs at 261 (waddr 0) and 519 (waddr 1); done at 519 only.
3. batch_num=0 -> done pulse at cycle 1, busy never asserted, no SRAM addresses change.
4. batch_num=18 -> vid_raddr sequence 0..15, 0, 1. next_waddr wraps identically. 18 batch_finish pulses and one done.
5. hold high for 5 cycles mid-STREAM -> every event after that point shifts by exactly 5 cycles, strobes are 0 during hold, and no beat is duplicated or lost.
6. rst_n low mid-STREAM, then start -> outputs 0 immediately. The new batch runs cleanly from row 0 with no stale write-back.
